rx_pkt_ctrl: RTL and testbench
==============================

Name: rx_pkt_ctrl

Overview:
Packet-level controller behind the USB 1.1 receiver control unit. It consumes rcving/w_enable/r_error/rcv_data and splits each packet into a PID register and an internal byte buffer. It tracks the byte count and holds the packet until the host side drains and acknowledges it. It also flags error, overflow and dropped-packet conditions to the host-side register block.

Parameters:
DEPTH, 64, data buffer depth in bytes; must be a power of 2 and at least 4.
CNT_W, $clog2(DEPTH)+1, byte_cnt width (default 7; range 0..DEPTH).

Ports:
clk  in  1  system clock
n_rst  in  1  reset; asynchronous, active-low
rcving  in  1  high while the receiver is inside a packet
w_enable  in  1  one-cycle strobe; rcv_data holds a complete byte
r_error  in  1  receiver error indication; level, may pulse
rcv_data  in  8  received byte
host_rd  in  1  pop one byte from the buffer
host_ack  in  1  host releases the packet; one-cycle pulse
rd_data  out  8  buffer head, first-word-fall-through; 0 when empty
rx_pid  out  4  PID of the held packet (PID byte bits [3:0])
byte_cnt  out  CNT_W  bytes currently in the buffer
pkt_ready  out  1  error-free packet held
pkt_err  out  1  errored packet held
overflow  out  1  buffer overflowed during the current packet
pkt_drop  out  1  a new packet arrived while one was held
busy  out  1  state is PID_CAP or DATA

Behaviour:
- Reset: state IDLE, buffer empty, err_seen=0.
- Reset values of all outputs: 0.
- Reset mid-packet aborts the packet with no flags set.
- FSM states: IDLE, PID_CAP, DATA, DONE, ERR. All state outputs are registered from state.
- IDLE:
  - rcving=1 -> PID_CAP; clear buffer, err_seen, overflow and rx_pid.
  - w_enable while in IDLE is ignored.
- PID_CAP:
  - w_enable -> rx_pid <= rcv_data[3:0]; state -> DATA. The PID byte is never pushed to the buffer.
  - rcving=0 before any w_enable -> ERR.
- DATA:
  - w_enable with buffer not full -> push rcv_data; byte_cnt increments on the following edge.
  - w_enable with buffer full -> byte discarded, overflow=1, err_seen=1. Remain in DATA until rcving=0.
  - rcving=0 -> DONE if err_seen=0, else ERR.
- err_seen is set by r_error=1 in any cycle of PID_CAP or DATA, including the cycle rcving falls.
- Latency: pkt_ready or pkt_err asserts on the first edge after the cycle in which rcving=0 is sampled.
- DONE/ERR (packet held):
  - host_rd with byte_cnt>0 pops; rd_data shows the next byte the following cycle.
  - host_rd with byte_cnt=0 is ignored, no underflow.
  - ERR buffer contents remain readable for debug.
  - host_ack -> IDLE; buffer flushed; pkt_ready, pkt_err and overflow clear the next cycle. rx_pid holds until the next packet starts.
  - host_rd and host_ack in the same cycle: ack wins, flush, no separate pop.
  - rcving rising while held -> packet ignored entirely; pkt_drop=1, sticky until host_ack.
  - After ack, if rcving is still high (dropped packet in progress), stay in IDLE until rcving=0, then resume normal detection. Never capture a partial packet.
- host_rd and host_ack in IDLE, PID_CAP or DATA are ignored.
- Buffer pointers: ADDR_W=$clog2(DEPTH) bits, wrap modulo DEPTH. Full when byte_cnt==DEPTH; empty when byte_cnt==0.
- Simultaneous push and pop cannot occur; pops are only accepted in DONE/ERR.

Optional Feature:
Macro RX_PKT_CRC_STRIP_EN.
- Defined: the last two bytes after the PID (CRC5/CRC16 field) are withheld from the buffer.
  - Data bytes pass through a 2-byte delay line. A byte is pushed only when a newer byte arrives.
  - On rcving fall the delay line is discarded.
  - A token packet (PID + 2 bytes) therefore yields byte_cnt=0.
  - Fewer than 2 post-PID bytes -> ERR.
  - Overflow is judged on actual pushes.
- Not defined: every post-PID byte is pushed; no minimum length is enforced.

Decomposition:
- Package rx_pkt_pkg:
  - rx_pkt_state_t enum (IDLE, PID_CAP, DATA, DONE, ERR)
  - DEF_DEPTH=64
  - PID constants PID_OUT=4'h1, PID_IN=4'h9, PID_SETUP=4'hD, PID_DATA0=4'h3, PID_DATA1=4'hB, PID_ACK=4'h2, PID_NAK=4'hA
- Sub-module rx_pkt_buf: DEPTH x 8 synchronous FIFO with push, pop, clear, FWFT rd_data and count. The FSM, error tracking and CRC strip stay in rx_pkt_ctrl.

Test Plan:
- rcving, w_enable bytes C3,11,22,33, rcving=0 -> rx_pid=3, byte_cnt=3, pkt_ready=1 one cycle later. Three host_rd pops return 11,22,33. host_ack -> all flags 0.
- r_error pulse during the 2nd data byte of a 4-byte packet -> pkt_err=1, pkt_ready=0, byte_cnt=3, buffer readable.
- DEPTH=64, packet PID + 66 bytes -> overflow=1, pkt_err=1, byte_cnt=64. First 64 bytes read back in order.
- Packet held, second packet with rcving high for 20 cycles before host_ack -> pkt_drop=1, held data unchanged. After ack and rcving fall, the next packet is captured normally.
- host_rd and host_ack in the same cycle with byte_cnt=3 -> byte_cnt=0, IDLE next cycle. rcving pulse with no w_enable -> pkt_err=1.
- RX_PKT_CRC_STRIP_EN defined: bytes 4B,AA,BB,C1,C2 -> rx_pid=B, byte_cnt=2 (AA,BB). Token E1,xx,yy -> pkt_ready=1, byte_cnt=0.

Source files
------------

// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: state type, default buffer depth and USB PID codes shared by the
// packet receive controller, its buffer and its bench.
package rx_pkt_pkg;
    typedef enum logic [2:0] {IDLE, PID_CAP, DATA, DONE, ERR} rx_pkt_state_t;
    localparam int DEF_DEPTH = 64;
    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
endpackage

// File: rtl/rx_pkt_if.sv
// rx_pkt_if: receiver-facing inputs and host-facing register signals of rx_pkt_ctrl.
// master drives the receiver/host side, slave is the controller.
interface rx_pkt_if #(parameter int CNT_W = 7);
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic [7:0]       rcv_data;
    logic             host_rd;
    logic             host_ack;
    logic [7:0]       rd_data;
    logic [3:0]       rx_pid;
    logic [CNT_W-1:0] byte_cnt;
    logic             pkt_ready;
    logic             pkt_err;
    logic             overflow;
    logic             pkt_drop;
    logic             busy;
    modport master (
        output rcving, w_enable, r_error, rcv_data, host_rd, host_ack,
        input  rd_data, rx_pid, byte_cnt, pkt_ready, pkt_err, overflow, pkt_drop, busy
    );
    modport slave (
        input  rcving, w_enable, r_error, rcv_data, host_rd, host_ack,
        output rd_data, rx_pid, byte_cnt, pkt_ready, pkt_err, overflow, pkt_drop, busy
    );
endinterface

// File: rtl/rx_pkt_buf.sv
// rx_pkt_buf: DEPTH x 8 synchronous FIFO with clear, first-word-fall-through head
// (0 when empty) and occupancy count; push when full and pop when empty are dropped.
module rx_pkt_buf #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clr,
    input  logic [7:0]       wr_data,
    output logic [7:0]       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp, rp;
    logic              do_push, do_pop;
    assign full    = count == CNT_W'(DEPTH);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && count != '0 && !clr;
    assign rd_data = count == '0 ? 8'h00 : mem[rp];
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + ADDR_W'(do_push);
            rp    <= rp + ADDR_W'(do_pop);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wr_data;
endmodule

// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: USB 1.1 packet-level receive controller; captures the PID, buffers the
// payload and holds the packet for the host. RX_PKT_CRC_STRIP_EN withholds the CRC bytes.
module rx_pkt_ctrl
    import rx_pkt_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic    clk,
    input logic    n_rst,
    rx_pkt_if.slave bus
);
    rx_pkt_state_t state, nxt;
    logic       held, in_pkt, start, ack_now;
    logic       push_req, ovf_now, err_nxt, short_pkt, full;
    logic       err_seen, wait_low, ovf, drop;
    logic [7:0] push_byte;
    logic [3:0] rx_pid;
    assign held    = state == DONE || state == ERR;
    assign in_pkt  = state == PID_CAP || state == DATA;
    // wait_low blocks capture of a packet that was already running when the host acked
    assign start   = state == IDLE && bus.rcving && !wait_low;
    assign ack_now = held && bus.host_ack;
`ifdef RX_PKT_CRC_STRIP_EN
    logic [7:0] dl_new, dl_old;
    logic [1:0] dl_n;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            dl_new <= '0;
            dl_old <= '0;
            dl_n   <= '0;
        end else if (start) begin
            dl_n <= '0;
        end else if (state == DATA && bus.w_enable) begin
            dl_new <= bus.rcv_data;
            dl_old <= dl_new;
            dl_n   <= dl_n == 2'd2 ? dl_n : dl_n + 2'd1;
        end
    // a byte leaves the delay line only once two newer bytes exist behind it
    assign push_req  = state == DATA && bus.w_enable && dl_n == 2'd2;
    assign push_byte = dl_old;
    assign short_pkt = dl_n != 2'd2 && !(dl_n == 2'd1 && bus.w_enable);
`else
    assign push_req  = state == DATA && bus.w_enable;
    assign push_byte = bus.rcv_data;
    assign short_pkt = 1'b0;
`endif
    assign ovf_now = push_req && full;
    assign err_nxt = err_seen || (in_pkt && bus.r_error) || ovf_now;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = start ? PID_CAP : IDLE;
            PID_CAP:   nxt = bus.w_enable ? DATA : bus.rcving ? PID_CAP : ERR;
            DATA:      nxt = bus.rcving ? DATA : (err_nxt || short_pkt) ? ERR : DONE;
            DONE, ERR: nxt = bus.host_ack ? IDLE : state;
            default:   nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.pkt_ready = state == DONE;
        bus.pkt_err   = state == ERR;
        bus.busy      = state == PID_CAP || state == DATA;
    end
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            rx_pid   <= '0;
            ovf      <= 1'b0;
            drop     <= 1'b0;
            err_seen <= 1'b0;
            wait_low <= 1'b0;
        end else begin
            rx_pid   <= start ? '0 : (state == PID_CAP && bus.w_enable) ? bus.rcv_data[3:0] : rx_pid;
            ovf      <= !(start || ack_now) && (ovf || ovf_now);
            drop     <= !ack_now && (drop || (held && bus.rcving));
            err_seen <= !start && err_nxt;
            wait_low <= bus.rcving && (wait_low || ack_now);
        end
    assign bus.rx_pid   = rx_pid;
    assign bus.overflow = ovf;
    assign bus.pkt_drop = drop;
    rx_pkt_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
        .clk     (clk),
        .n_rst   (n_rst),
        .push    (push_req),
        .pop     (held && bus.host_rd && !bus.host_ack),
        .clr     (start || ack_now),
        .wr_data (push_byte),
        .rd_data (bus.rd_data),
        .count   (bus.byte_cnt),
        .full    (full)
    );
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb_rx_pkt_ctrl: directed and randomized bench for rx_pkt_ctrl with a queue-based packet model.
// Define RX_PKT_CRC_STRIP_EN for both bench and design to cover the CRC-strip build.
module tb_rx_pkt_ctrl;
    import rx_pkt_pkg::*;
    localparam int DEPTH = DEF_DEPTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef RX_PKT_CRC_STRIP_EN
    localparam int STRIP = 1;
`else
    localparam int STRIP = 0;
`endif
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [3:0] pids [7] = '{PID_OUT, PID_IN, PID_SETUP, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK};

    rx_pkt_if #(.CNT_W(CNT_W)) bus();
    rx_pkt_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] pidb(input logic [3:0] p);
        return {~p, p};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: the buffer is a queue, the CRC delay line a second queue.
    logic [7:0] mq[$], dq[$];
    logic [3:0] m_pid;
    bit m_in, m_pid_got, m_held, m_bad, m_err, m_ovf, m_drop, m_wait;

    task automatic model_store(input logic [7:0] b);
        logic [7:0] x;
        x = b;
        if (STRIP == 1) begin
            dq.push_back(b);
            if (dq.size() <= 2) return;
            x = dq.pop_front();
        end
        if (mq.size() == DEPTH) begin
            m_ovf = 1;
            m_err = 1;
        end else mq.push_back(x);
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mq.delete();
            dq.delete();
            m_pid = 0;
            {m_in, m_pid_got, m_held, m_bad, m_err, m_ovf, m_drop, m_wait} = '0;
        end else if (m_held) begin
            if (bus.host_ack) begin
                m_held = 0;
                mq.delete();
                m_ovf = 0;
                m_drop = 0;
                m_wait = bus.rcving;
            end else begin
                if (bus.host_rd && mq.size() != 0) mq.delete(0);
                if (bus.rcving) m_drop = 1;
            end
        end else if (!m_in) begin
            if (m_wait) m_wait = bus.rcving;
            else if (bus.rcving) begin
                m_in = 1;
                m_pid_got = 0;
                m_err = 0;
                m_ovf = 0;
                m_pid = 0;
                mq.delete();
                dq.delete();
            end
        end else begin
            if (bus.r_error) m_err = 1;
            if (!m_pid_got) begin
                if (bus.w_enable) begin
                    m_pid = bus.rcv_data[3:0];
                    m_pid_got = 1;
                end else if (!bus.rcving) begin
                    m_in = 0;
                    m_held = 1;
                    m_bad = 1;
                end
            end else begin
                if (bus.w_enable) model_store(bus.rcv_data);
                if (!bus.rcving) begin
                    m_in = 0;
                    m_held = 1;
                    m_bad = m_err || (STRIP == 1 && dq.size() < 2);
                end
            end
        end
    end

    always @(negedge clk) if (n_rst) begin
        chk("rd_data", bus.rd_data, mq.size() != 0 ? mq[0] : 8'h00);
        chk("byte_cnt", bus.byte_cnt, mq.size());
        chk("rx_pid", bus.rx_pid, m_pid);
        chk("pkt_ready", bus.pkt_ready, m_held && !m_bad);
        chk("pkt_err", bus.pkt_err, m_held && m_bad);
        chk("overflow", bus.overflow, m_ovf);
        chk("pkt_drop", bus.pkt_drop, m_drop);
        chk("busy", bus.busy, m_in);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        bus.rcving = 0;
        bus.w_enable = 0;
        bus.r_error = 0;
        bus.rcv_data = 0;
        bus.host_rd = 0;
        bus.host_ack = 0;
    endtask

    task automatic send(input bq_t b, input int err_at);
        bus.rcving = 1;
        tick();
        foreach (b[i]) begin
            bus.w_enable = 1;
            bus.rcv_data = b[i];
            bus.r_error = i == err_at;
            tick();
            bus.w_enable = 0;
            bus.r_error = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
        bus.rcving = 0;
        tick();
    endtask

    task automatic rd();
        bus.host_rd = 1;
        tick();
        bus.host_rd = 0;
    endtask

    task automatic ack();
        bus.host_ack = 1;
        tick();
        bus.host_ack = 0;
    endtask

    initial begin
        bq_t p;
        quiet();
        repeat (2) tick();
        chk("rst_ready", bus.pkt_ready, 0);
        chk("rst_err", bus.pkt_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.byte_cnt, 0);
        chk("rst_rd", bus.rd_data, 0);
        n_rst = 1;
        tick();
        // basic packet
        p = '{pidb(PID_DATA0), 8'h11, 8'h22, 8'h33};
        send(p, -1);
        chk("t1_pid", bus.rx_pid, 4'h3);
        chk("t1_ready", bus.pkt_ready, 1);
        chk("t1_cnt", bus.byte_cnt, 3 - 2 * STRIP);
        chk("t1_model_cnt", mq.size(), 3 - 2 * STRIP);
        chk("t1_rd0", bus.rd_data, 8'h11);
        rd();
        chk("t1_rd1", bus.rd_data, STRIP == 1 ? 8'h00 : 8'h22);
        rd();
        chk("t1_rd2", bus.rd_data, STRIP == 1 ? 8'h00 : 8'h33);
        rd();
        chk("t1_empty", bus.byte_cnt, 0);
        ack();
        chk("t1_ack_ready", bus.pkt_ready, 0);
        chk("t1_ack_busy", bus.busy, 0);
        // r_error on the second data byte
        p = '{pidb(PID_DATA1), 8'hAA, 8'hBB, 8'hCC};
        send(p, 2);
        chk("t2_err", bus.pkt_err, 1);
        chk("t2_ready", bus.pkt_ready, 0);
        chk("t2_cnt", bus.byte_cnt, 3 - 2 * STRIP);
        chk("t2_rd", bus.rd_data, 8'hAA);
        ack();
        // overflow
        p = '{pidb(PID_DATA0)};
        for (int i = 0; i < 66 + 2 * STRIP; i++) p.push_back(8'(i));
        send(p, -1);
        chk("t3_ovf", bus.overflow, 1);
        chk("t3_err", bus.pkt_err, 1);
        chk("t3_cnt", bus.byte_cnt, 64);
        chk("t3_model_cnt", mq.size(), 64);
        for (int i = 0; i < 64; i++) begin
            chk("t3_rd", bus.rd_data, i);
            rd();
        end
        rd();
        chk("t3_underflow_cnt", bus.byte_cnt, 0);
        chk("t3_underflow_rd", bus.rd_data, 0);
        ack();
        chk("t3_ack_ovf", bus.overflow, 0);
        // dropped packet while one is held
        p = '{pidb(PID_IN), 8'h01, 8'h02, 8'h03};
        send(p, -1);
        bus.rcving = 1;
        for (int i = 0; i < 20; i++) begin
            bus.w_enable = i[0];
            bus.rcv_data = 8'hE0 + 8'(i);
            tick();
        end
        bus.w_enable = 0;
        chk("t4_drop", bus.pkt_drop, 1);
        chk("t4_cnt", bus.byte_cnt, 3 - 2 * STRIP);
        chk("t4_pid", bus.rx_pid, PID_IN);
        chk("t4_rd", bus.rd_data, 8'h01);
        ack();
        repeat (3) tick();
        chk("t4_wait_busy", bus.busy, 0);
        chk("t4_wait_drop", bus.pkt_drop, 0);
        chk("t4_wait_pid", bus.rx_pid, PID_IN);
        bus.rcving = 0;
        tick();
        p = '{pidb(PID_SETUP), 8'h44, 8'h55, 8'h66};
        send(p, -1);
        chk("t4_next_pid", bus.rx_pid, PID_SETUP);
        chk("t4_next_ready", bus.pkt_ready, 1);
        // host_rd with host_ack, then a PID-less packet
        p = '{pidb(PID_DATA0), 8'h01, 8'h02, 8'h03};
        send(p, -1);
        chk("t5_cnt", bus.byte_cnt, 3 - 2 * STRIP);
        bus.host_rd = 1;
        bus.host_ack = 1;
        tick();
        quiet();
        chk("t5_cnt0", bus.byte_cnt, 0);
        chk("t5_idle", bus.pkt_ready | bus.busy, 0);
        bus.rcving = 1;
        tick();
        bus.rcving = 0;
        tick();
        chk("t5_nopid_err", bus.pkt_err, 1);
        ack();
        // CRC-strip vectors
        p = '{8'h4B, 8'hAA, 8'hBB, 8'hC1, 8'hC2};
        send(p, -1);
        chk("t6_pid", bus.rx_pid, PID_DATA1);
        chk("t6_cnt", bus.byte_cnt, STRIP == 1 ? 2 : 4);
        chk("t6_rd", bus.rd_data, 8'hAA);
        ack();
        p = '{pidb(PID_OUT), 8'h5A, 8'hA5};
        send(p, -1);
        chk("t6_tok_ready", bus.pkt_ready, 1);
        chk("t6_tok_cnt", bus.byte_cnt, STRIP == 1 ? 0 : 2);
        ack();
        p = '{pidb(PID_OUT), 8'h12};
        send(p, -1);
        chk("t6_short_err", bus.pkt_err, STRIP);
        ack();
        // reset in the middle of a packet
        bus.rcving = 1;
        tick();
        bus.w_enable = 1;
        bus.rcv_data = pidb(PID_DATA1);
        repeat (3) tick();
        n_rst = 0;
        #1;
        chk("t7_busy", bus.busy, 0);
        chk("t7_cnt", bus.byte_cnt, 0);
        chk("t7_pid", bus.rx_pid, 0);
        quiet();
        tick();
        n_rst = 1;
        tick();
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 11) == 0) bus.rcving = ~bus.rcving;
            bus.w_enable = 1'($urandom_range(0, 1));
            bus.rcv_data = $urandom_range(0, 3) == 0 ? pidb(pids[$urandom_range(0, 6)]) : 8'($urandom);
            bus.r_error = $urandom_range(0, 59) == 0;
            bus.host_rd = $urandom_range(0, 2) == 0;
            bus.host_ack = $urandom_range(0, 14) == 0;
            tick();
        end
        quiet();
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
